// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared state type and reset defaults for led_bound_sequencer
// Default table reproduces the 16->6->11->0->6->0 flash pattern.
package led_seq_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} seq_state_e;

  localparam int DEF_LED_W     = 16;
  localparam int DEF_LVL_W     = $clog2(DEF_LED_W + 1);
  localparam int DEF_MAX_STEPS = 8;
  localparam int DEF_LEN       = 6;
  localparam int DEF_TABLE [DEF_LEN] = '{16, 6, 11, 0, 6, 0};
  localparam logic [DEF_LED_W:0] DEF_KICK_MASK = 17'h00041;

  function automatic int def_level(input int i);
    return (i < DEF_LEN) ? DEF_TABLE[i] : 0;
  endfunction

endpackage

// File: rtl/led_thermo_enc.sv
// rtl/led_thermo_enc.sv - level to thermometer-coded LED bus, led = (1<<level)-1
module led_thermo_enc
  import led_seq_pkg::*;
#(
  parameter int LED_W = DEF_LED_W,
  parameter int LVL_W = DEF_LVL_W
) (
  input  logic [LVL_W-1:0] level,
  output logic [LED_W-1:0] led
);

  always_comb begin
    led = '0;
    for (int i = 0; i < LED_W; i++) begin
      led[i] = (32'(level) > i);
    end
  end

endmodule

// File: rtl/led_bound_sequencer.sv
// rtl/led_bound_sequencer.sv - table-driven LED bar sequencer, one level step per clock
// Optional kickback on flick in RUN is enabled by defining LED_SEQ_KICKBACK_EN.
module led_bound_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W     = DEF_LED_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS,
  parameter int LVL_W     = $clog2(LED_W + 1),
  parameter int IDX_W     = $clog2(MAX_STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flick,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [LVL_W-1:0] cfg_level,
  input  logic             len_we,
  input  logic [IDX_W:0]   len_in,
  input  logic             kick_we,
  input  logic [LED_W:0]   kick_mask,
  output logic [LED_W-1:0] led,
  output logic [LVL_W-1:0] level,
  output logic [IDX_W-1:0] step_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LED_W);
  localparam logic [IDX_W:0]   LEN_MAX = (IDX_W+1)'(MAX_STEPS);
  localparam logic [IDX_W:0]   LEN_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  seq_state_e       state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [LVL_W-1:0] tbl_q [MAX_STEPS];
  logic [LVL_W-1:0] tbl_d [MAX_STEPS];
  logic [LVL_W-1:0] target;
  logic             last_step;
  logic             kick;

  assign target    = tbl_q[idx_q];
  assign last_step = ({1'b0, idx_q} == (len_q - LEN_ONE));

`ifdef LED_SEQ_KICKBACK_EN
  logic [LED_W:0]   kick_q, kick_d;
  logic [LVL_W-1:0] prev_target;

  // "Descending into" a target means the previous table entry sits above it.
  assign prev_target = tbl_q[idx_q - IDX_ONE];
  assign kick = flick && (idx_q != '0) && !last_step && kick_q[level_q] &&
                ((target < level_q) || ((level_q == target) && (prev_target > target)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) kick_q <= (LED_W+1)'(DEF_KICK_MASK);
    else        kick_q <= kick_d;
  end
`else
  logic unused_kick;
  assign unused_kick = ^{kick_we, kick_mask};
  assign kick = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      len_q   <= (IDX_W+1)'(DEF_LEN);
      for (int i = 0; i < MAX_STEPS; i++) begin
        tbl_q[i] <= LVL_W'(def_level(i));
      end
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      len_q   <= len_d;
      tbl_q   <= tbl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    len_d   = len_q;
    tbl_d   = tbl_q;
`ifdef LED_SEQ_KICKBACK_EN
    kick_d  = kick_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Configuration is only accepted here; the table is frozen while busy.
        if (cfg_we) tbl_d[cfg_addr] = (cfg_level > LVL_MAX) ? LVL_MAX : cfg_level;
        if (len_we && (len_in != '0) && (len_in <= LEN_MAX)) len_d = len_in;
`ifdef LED_SEQ_KICKBACK_EN
        if (kick_we) kick_d = kick_mask;
`endif
        if ((start || flick) && (len_q != '0)) begin
          state_d = RUN;
          level_d = '0;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (kick) begin
          idx_d   = idx_q - IDX_ONE;
          level_d = level_q + 1'b1;
        end else if (level_q < target) begin
          level_d = level_q + 1'b1;
        end else if (level_q > target) begin
          level_d = level_q - 1'b1;
        end else if (!last_step) begin
          idx_d = idx_q + IDX_ONE;
        end else begin
          state_d = IDLE;
          level_d = '0;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level    = level_q;
  assign step_idx = idx_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

  led_thermo_enc #(
    .LED_W(LED_W),
    .LVL_W(LVL_W)
  ) u_thermo (
    .level(level_q),
    .led  (led)
  );

endmodule

// File: tb/tb_led_bound_sequencer.sv
// tb/tb_led_bound_sequencer.sv - randomized scoreboard bench for led_bound_sequencer
module tb_led_bound_sequencer;

  localparam int LED_W = 16;
  localparam int MAX_STEPS = 8;
  localparam int LVL_W = 5;
  localparam int IDX_W = 3;
`ifdef LED_SEQ_KICKBACK_EN
  localparam bit KICK_EN = 1'b1;
`else
  localparam bit KICK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, flick = 1'b0, cfg_we = 1'b0, len_we = 1'b0, kick_we = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [LVL_W-1:0] cfg_level = '0;
  logic [IDX_W:0]   len_in = '0;
  logic [LED_W:0]   kick_mask_in = '0;
  logic [LED_W-1:0] led;
  logic [LVL_W-1:0] level;
  logic [IDX_W-1:0] step_idx;
  logic             busy, done;

  always #5 clk = ~clk;

  led_bound_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .flick(flick),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_level(cfg_level),
    .len_we(len_we), .len_in(len_in), .kick_we(kick_we), .kick_mask(kick_mask_in),
    .led(led), .level(level), .step_idx(step_idx), .busy(busy), .done(done)
  );

  typedef struct {int level; int idx; bit busy; bit done;} exp_t;
  exp_t exp_q[$];
  exp_t trace[$];
  bit   flick_plan[$];
  int   mdl_tbl [MAX_STEPS];
  int   mdl_len;
  bit [LED_W:0] mdl_kick;
  int   checks = 0, errors = 0;
  int   busy_cnt = 0, last_busy_len = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int thermo(input int l);
    return (1 << l) - 1;
  endfunction

  function automatic void model_reset();
    int d [MAX_STEPS];
    d = '{16, 6, 11, 0, 6, 0, 0, 0};
    for (int i = 0; i < MAX_STEPS; i++) mdl_tbl[i] = d[i];
    mdl_len  = 6;
    mdl_kick = 17'h00041;
  endfunction

  function automatic bit plan_at(input int p);
    return (p < flick_plan.size()) ? flick_plan[p] : 1'b0;
  endfunction

  // Walk from (i0,l0) toward each remaining target; every entry is one busy cycle.
  function automatic void append_from(input int i0, input int l0);
    int l, t;
    exp_t e;
    for (int k = i0; k < mdl_len; k++) begin
      l = (k == i0) ? l0 : mdl_tbl[k-1];
      t = mdl_tbl[k];
      forever begin
        e.level = l; e.idx = k; e.busy = 1'b1; e.done = 1'b0;
        trace.push_back(e);
        if (l == t) break;
        l += (l < t) ? 1 : -1;
      end
    end
  endfunction

  function automatic bit qualifies(input exp_t e);
    int t;
    if (e.idx == 0 || e.idx == mdl_len - 1 || !mdl_kick[e.level]) return 1'b0;
    t = mdl_tbl[e.idx];
    return (t < e.level) || (e.level == t && mdl_tbl[e.idx-1] > t);
  endfunction

  function automatic void build_trace();
    exp_t e;
    trace.delete();
    append_from(0, 0);
    for (int p = 0; p < trace.size(); p++) begin
      if (KICK_EN && plan_at(p) && qualifies(trace[p])) begin
        e = trace[p];
        while (trace.size() > p + 1) void'(trace.pop_back());
        append_from(e.idx - 1, e.level + 1);
      end
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      busy_cnt = 0;
    end else if (busy || done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: level=%0d busy=%0d done=%0d, nothing expected", level, busy, done);
      end else begin
        e = exp_q.pop_front();
        chk("level", int'(level), e.level);
        chk("step_idx", int'(step_idx), e.idx);
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
        chk("led", int'(led), thermo(e.level));
      end
      if (busy) busy_cnt++;
      if (done) begin
        last_busy_len = busy_cnt;
        busy_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int l);
    cfg_we = 1'b1; cfg_addr = IDX_W'(a); cfg_level = LVL_W'(l);
    tick();
    cfg_we = 1'b0;
    mdl_tbl[a] = (l > LED_W) ? LED_W : l;
  endtask

  task automatic write_len(input int n);
    len_we = 1'b1; len_in = (IDX_W+1)'(n);
    tick();
    len_we = 1'b0;
    if (n >= 1 && n <= MAX_STEPS) mdl_len = n;
  endtask

  task automatic write_kick(input logic [LED_W:0] m);
    kick_we = 1'b1; kick_mask_in = m;
    tick();
    kick_we = 1'b0;
    if (KICK_EN) mdl_kick = m;
  endtask

  task automatic push_expected();
    exp_t e;
    build_trace();
    foreach (trace[i]) exp_q.push_back(trace[i]);
    e.level = 0; e.idx = 0; e.busy = 1'b0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // how: 0 = start, 1 = flick, 2 = both; exp_len < 0 skips the busy-length check.
  task automatic run_seq(input int how, input int exp_len, input bit run_writes);
    int n;
    push_expected();
    n = trace.size();
    start = (how != 1);
    flick = (how != 0);
    tick();
    start = 1'b0;
    for (int p = 0; p < n + 2; p++) begin
      if (run_writes && p == 3) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_level = 5'd3;
        len_we = 1'b1; len_in = 4'd2;
        kick_we = 1'b1; kick_mask_in = '1;
      end else begin
        cfg_we = 1'b0; len_we = 1'b0; kick_we = 1'b0;
      end
      flick = (p < n) ? plan_at(p) : 1'b0;
      tick();
    end
    flick = 1'b0;
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expected outputs never appeared", exp_q.size());
      exp_q.delete();
    end
    if (exp_len >= 0) chk("busy_cycles", last_busy_len, exp_len);
    repeat (2) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_step_idx", int'(step_idx), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    tick();

    flick_plan.delete();
    run_seq(0, 60, 1'b0);
    run_seq(2, 60, 1'b1);
    run_seq(1, 60, 1'b0);

`ifdef LED_SEQ_KICKBACK_EN
    for (int p = 0; p < 28; p++) flick_plan.push_back(p == 27);
    run_seq(0, 81, 1'b0);
    flick_plan.delete();
    for (int p = 0; p < 60; p++) flick_plan.push_back(p >= 53);
    run_seq(0, 60, 1'b0);
`else
    for (int p = 0; p < 60; p++) flick_plan.push_back(1'b1);
    run_seq(0, 60, 1'b0);
`endif
    flick_plan.delete();

    write_len(2);
    write_entry(0, 4);
    write_entry(1, 0);
    run_seq(0, 10, 1'b0);
    write_len(0);
    write_len(9);
    run_seq(0, 10, 1'b0);

    repeat (8) begin
      write_len($urandom_range(0, 15));
      n = $urandom_range(1, MAX_STEPS);
      write_len(n);
      for (int i = 0; i < n; i++) write_entry(i, $urandom_range(0, 20));
      write_kick(17'($urandom));
      flick_plan.delete();
      for (int p = 0; p < 150; p++) flick_plan.push_back($urandom_range(0, 5) == 0);
      run_seq($urandom_range(0, 2), -1, 1'b0);
    end
    flick_plan.delete();

    write_entry(0, 16);
    write_len(1);
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      if (level == 5'd9) found = 1'b1;
      else tick();
    end
    chk("reach_level9", int'(found), 1);
    reset = 1'b0;
    #1;
    chk("abort_level", int'(level), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_led", int'(led), 0);
    chk("abort_step_idx", int'(step_idx), 0);
    exp_q.delete();
    model_reset();
    tick();
    reset = 1'b1;
    tick();
    run_seq(0, 60, 1'b0);
`ifdef LED_SEQ_KICKBACK_EN
    for (int p = 0; p < 28; p++) flick_plan.push_back(p == 27);
    run_seq(0, 81, 1'b0);
    flick_plan.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_bound_sequencer.md
# led_bound_sequencer

Programmable sequencer for the 16-LED bound-flasher bar. It stores a table of target levels and a kickback mask, and walks the bar level up and down through the table one LED per clock. It drives the thermometer-coded LED bus and reports busy/done to the system controller. Fully synchronous except reset. Its default table reproduces the existing 16→6→11→0→6→0 flash pattern.

## Interface
- LED_W, 16: bar width; level range 0..LED_W
- MAX_STEPS, 8: table depth
- LVL_W, $clog2(LED_W+1): level width (5)
- IDX_W, $clog2(MAX_STEPS): index width (3)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  begin sequence (sampled in IDLE)
- flick  in  1  pre-synchronized; start in IDLE, kickback request in RUN
- cfg_we  in  1  table write strobe
- cfg_addr  in  IDX_W  table entry
- cfg_level  in  LVL_W  target level; values >LED_W clamp to LED_W
- len_we  in  1  length write strobe
- len_in  in  IDX_W+1  active entries, 1..MAX_STEPS; 0 or >MAX_STEPS ignored
- kick_we  in  1  kickback mask write strobe
- kick_mask  in  LED_W+1  bit n set = level n is a kickback point
- led  out  LED_W  thermometer: (1<<level)-1
- level  out  LVL_W  current level
- step_idx  out  IDX_W  current table index
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after sequence end

## Operation
- Reset values:
  - state IDLE; level 0; step_idx 0; led 0; busy 0; done 0.
  - Table = {16,6,11,0,6,0}; len 6; kick_mask = levels 0 and 6.
  - Reset mid-run aborts immediately and restores all defaults.
- States: IDLE, RUN.
- IDLE:
  - Config writes take effect at the clock edge.
  - start or flick with len≥1 → RUN, idx 0, level 0.
  - start and flick together count as one start.
- RUN, each cycle, with target = table[idx]:
  - level<target: level+1.
  - level>target: level−1.
  - level==target and idx<len−1: idx+1, level held.
  - level==target and idx==len−1: → IDLE, level 0, idx 0, done pulses next cycle.
- All cfg_we/len_we/kick_we strobes in RUN are dropped; the table is frozen while busy.
- start in RUN is ignored.
- Kickback: see Configuration.

## Timing
- start sampled at edge N → busy=1 and level=0 from cycle N+1.
- One level step per clock.
- Segment 0 occupies target+1 cycles.
- Each later segment occupies |Δ|+1 cycles; the +1 is the hold cycle at index advance.
- Default table: busy high exactly 60 cycles, then done=1 for 1 cycle with level=0.
- Outputs are registered except led, which is decoded from the level register.

## Configuration
- LED_SEQ_KICKBACK_EN defined:
  - Kickback fires in RUN when flick=1, target<level or level==target while descending into it, kick_mask[level]=1, idx≠0, and idx≠len−1.
  - Kickback takes priority over the normal update: idx←idx−1, level←level+1.
  - Sequence then climbs toward the previous target.
  - Repeats every qualifying cycle while flick is held.
- Undefined:
  - flick ignored in RUN; only acts as start in IDLE.
  - kick_we and the mask register are removed.

## Structure
- Package led_seq_pkg holds:
  - state enum {IDLE, RUN}
  - LED_W/LVL_W defaults
  - default table constants
  - default length
  - default kick mask
- Sub-module led_thermo_enc: level → thermometer led bus.

## Test plan
- Defaults, pulse start: level runs 0→16→6→11→0→6→0; busy 60 cycles; done single pulse; led=16'h003F when level=6.
- Kickback (macro on): flick=1 for one cycle when level=6 in segment 1 (descending from 16) → next cycle idx=0, level=7, climbs to 16 again; busy extends by 21 cycles.
- Last segment (macro on): flick held through segment 5 (6→0) → no kickback, normal done.
- Reprogram in IDLE: len=2, table {4,0} → levels 0..4..0; busy 10 cycles.
- During RUN: cfg_we to entry 0 with 3 → ignored, and the next run still reaches 16.
- Reset low at level 9 mid-run → level=0, busy=0, led=0 immediately; table restored to defaults.
